// File: rtl/i2c_config_sequencer.sv
// rtl/i2c_config_sequencer.sv - sequences a table of 16-bit register writes through the I2C bus master
// One transfer at a time: load word, pulse begin_transmition, wait for completion, retry on timeout.
module i2c_config_sequencer #(
   parameter int         NUM_REGS       = 11,
   parameter logic [6:0] DEV_ADDR       = 7'h1A,
   parameter int         STARTUP_CYCLES = 1024,
   parameter int         GAP_CYCLES     = 64,
   parameter int         TIMEOUT_CYCLES = 8192,
   parameter int         MAX_RETRIES    = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [7:0]  tbl_index,
   input  logic [15:0] tbl_data,
   output logic        begin_transmition,
   output logic [15:0] dataToSend,
   output logic [6:0]  Receiver_address,
   output logic        r_w,
   input  logic        transmition_over,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  err_index
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_STARTUP = 3'd1;
   localparam logic [2:0] S_LOAD    = 3'd2;
   localparam logic [2:0] S_ASSERT  = 3'd3;
   localparam logic [2:0] S_WAIT    = 3'd4;
   localparam logic [2:0] S_GAP     = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;
   localparam logic [2:0] S_ERROR   = 3'd7;

   localparam logic [15:0] STARTUP_LAST = 16'(STARTUP_CYCLES - 1);
   localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]  LAST_INDEX   = 8'(NUM_REGS - 1);
   localparam logic [2:0]  RETRY_LIMIT  = 3'(MAX_RETRIES);

   logic [2:0]  state;
   logic [15:0] cnt;
   logic [2:0]  retry;
   logic        resend;
   logic [2:0]  retry_next;

   assign Receiver_address = DEV_ADDR;
   assign r_w              = 1'b0;
   assign retry_next       = retry + 3'd1;

   // begin_transmition is a flop so the bus master sees a clean falling edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= S_IDLE;
         cnt               <= 16'd0;
         retry             <= 3'd0;
         resend            <= 1'b0;
         tbl_index         <= 8'd0;
         dataToSend        <= 16'd0;
         begin_transmition <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
         error             <= 1'b0;
         err_index         <= 8'd0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state     <= S_STARTUP;
                  cnt       <= 16'd0;
                  tbl_index <= 8'd0;
                  retry     <= 3'd0;
                  resend    <= 1'b0;
                  done      <= 1'b0;
                  error     <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            S_STARTUP: begin
               if (cnt == STARTUP_LAST) begin
                  state <= S_LOAD;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_LOAD: begin
               dataToSend        <= tbl_data;
               begin_transmition <= 1'b1;
               cnt               <= 16'd0;
               state             <= S_ASSERT;
            end
            S_ASSERT: begin
               if (cnt == 16'd1) begin
                  begin_transmition <= 1'b0;
                  cnt               <= 16'd0;
                  state             <= S_WAIT;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_WAIT: begin
               // a completion arriving in the timeout cycle still wins
               if (transmition_over) begin
                  retry <= 3'd0;
                  cnt   <= 16'd0;
                  if (tbl_index == LAST_INDEX) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                  end else begin
                     state     <= S_GAP;
                     tbl_index <= tbl_index + 8'd1;
                     resend    <= 1'b0;
                  end
               end else if (cnt == TIMEOUT_LAST) begin
                  retry <= retry_next;
                  cnt   <= 16'd0;
                  if (retry_next == RETRY_LIMIT) begin
                     state     <= S_ERROR;
                     error     <= 1'b1;
                     busy      <= 1'b0;
                     err_index <= tbl_index;
                  end else begin
                     state  <= S_GAP;
                     resend <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            S_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt <= 16'd0;
                  if (resend) begin
                     state             <= S_ASSERT;
                     begin_transmition <= 1'b1;
                  end else begin
                     state <= S_LOAD;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
